// File: rtl/wash_cycle_controller.sv
// ============================================================================
// wash_cycle_controller: washing-machine master sequencer with timer handshake
// Rev 1.0
// ============================================================================
`default_nettype none

module wash_cycle_controller #(
  parameter int LOAD_W  = 3,
  parameter int STATE_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              cancel,
  input  logic              door_closed,
  input  logic [LOAD_W-1:0] load_sel,
  input  logic              td,
  input  logic              tf,
  input  logic              tw,
  input  logic              tr,
  input  logic              ts,
  output logic              tmr_clr,
  output logic [LOAD_W-1:0] tmr_load,
  output logic              door_lock,
  output logic              water_valve,
  output logic              motor_agitate,
  output logic              motor_spin,
  output logic              drain_pump,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [STATE_W-1:0] state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOCK  = 3'd1,
    FILL  = 3'd2,
    WASH  = 3'd3,
    RINSE = 3'd4,
    SPIN  = 3'd5,
    DONE  = 3'd6,
    ABORT = 3'd7
  } state_t;

  state_t            cur_state, nxt_state;
  logic              armed;
  logic              phase_flag;
  logic              running;
  logic              start_ok;
  logic              clr_nxt;
  logic [LOAD_W-1:0] load_clamped;

  assign load_clamped = (load_sel > LOAD_W'(2)) ? LOAD_W'(2) : load_sel;
  assign state        = STATE_W'(cur_state);

  always_comb begin
    nxt_state     = cur_state;
    phase_flag    = 1'b0;
    start_ok      = 1'b0;
    door_lock     = 1'b0;
    water_valve   = 1'b0;
    motor_agitate = 1'b0;
    motor_spin    = 1'b0;
    drain_pump    = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;

    case (cur_state)
      LOCK:  begin phase_flag = td; door_lock = 1'b1; busy = 1'b1; end
      FILL:  begin phase_flag = tf; door_lock = 1'b1; water_valve = 1'b1; busy = 1'b1; end
      WASH:  begin phase_flag = tw; door_lock = 1'b1; motor_agitate = 1'b1; busy = 1'b1; end
      RINSE: begin
        phase_flag    = tr;
        door_lock     = 1'b1;
        water_valve   = 1'b1;
        motor_agitate = 1'b1;
        busy          = 1'b1;
      end
      SPIN:  begin
        phase_flag = ts;
        door_lock  = 1'b1;
        motor_spin = 1'b1;
        drain_pump = 1'b1;
        busy       = 1'b1;
      end
      ABORT: begin phase_flag = ts; door_lock = 1'b1; drain_pump = 1'b1; busy = 1'b1; end
      DONE:  done = 1'b1;
      default: ;
    endcase

    running = (cur_state == LOCK) || (cur_state == FILL) || (cur_state == WASH) ||
              (cur_state == RINSE) || (cur_state == SPIN);

    // Faults outrank the phase flag, which outranks a new start.
    if (running && (cancel || !door_closed)) begin
      nxt_state = (cur_state == LOCK) ? IDLE : ABORT;
    end else if ((cur_state == DONE) && cancel) begin
      nxt_state = IDLE;
    end else if (armed && phase_flag) begin
      case (cur_state)
        LOCK:    nxt_state = FILL;
        FILL:    nxt_state = WASH;
        WASH:    nxt_state = RINSE;
        RINSE:   nxt_state = SPIN;
        SPIN:    nxt_state = DONE;
        ABORT:   nxt_state = IDLE;
        default: nxt_state = cur_state;
      endcase
    end else if (((cur_state == IDLE) || (cur_state == DONE)) && start && door_closed) begin
      nxt_state = LOCK;
      start_ok  = 1'b1;
    end

    clr_nxt = (nxt_state == IDLE) || (nxt_state == DONE) || (nxt_state != cur_state);
  end

  // armed rises one edge after tmr_clr falls, so a phase lasts at least 3 cycles
  // and flags left over from the previous phase are never sampled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_state <= IDLE;
      tmr_clr   <= 1'b1;
      armed     <= 1'b0;
      aborted   <= 1'b0;
      tmr_load  <= '0;
    end else begin
      cur_state <= nxt_state;
      tmr_clr   <= clr_nxt;
      armed     <= !tmr_clr && !clr_nxt;
      if (start_ok) begin
        tmr_load <= load_clamped;
        aborted  <= 1'b0;
      end else if ((nxt_state == ABORT) && (cur_state != ABORT)) begin
        aborted <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire
